// File: rtl/regwrite_arbiter_pkg.sv
// Purpose: shared types for the register-bank write-port arbiter.
//   regwrite_state_t : arbiter FSM states.
//   reg_write_t      : register-bank write bundle (enable, index, data),
//                      the same shape the writeback stage produces.
package regwrite_arbiter_pkg;

  localparam int unsigned REG_IDX_W  = 4;
  localparam int unsigned NUM_REGS   = 2 ** REG_IDX_W;
  localparam int unsigned REG_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    FORCE = 2'd2
  } regwrite_state_t;

  typedef struct packed {
    logic                  en;
    logic [REG_IDX_W-1:0]  index;
    logic [REG_DATA_W-1:0] data;
  } reg_write_t;

endpackage

// File: rtl/regwrite_hold.sv
// Purpose: one-entry hold register for a secondary-unit result waiting for
//   the register-bank write port, plus a one-hot decode of its index.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   i_load          : capture i_data/i_index (wins over i_clear)
//   i_clear         : empty the entry
//   i_data, i_index : entry payload
//   o_valid         : entry occupied
//   o_data, o_index : held payload
//   o_busy_mask     : one-hot of o_index when occupied, else 0
module regwrite_hold
  import regwrite_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IDX_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic                  i_clear,
  input  logic [DATA_W-1:0]     i_data,
  input  logic [IDX_W-1:0]      i_index,
  output logic                  o_valid,
  output logic [DATA_W-1:0]     o_data,
  output logic [IDX_W-1:0]      o_index,
  output logic [2**IDX_W-1:0]   o_busy_mask
);

  localparam int unsigned NREG = 2 ** IDX_W;

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [IDX_W-1:0]  r_index;
  logic [NREG-1:0]   w_mask;

  // Load has priority so a drain and a refill in the same cycle keep the entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end
  end

  // Payload needs no reset: it is only observed while r_valid is set.
  always_ff @(posedge clk) begin
    if (i_load) begin
      r_data  <= i_data;
      r_index <= i_index;
    end
  end

  // Decode depends on registered state only.
  always_comb begin
    w_mask = '0;
    if (r_valid) begin
      w_mask = NREG'(1) << r_index;
    end
  end

  assign o_valid     = r_valid;
  assign o_data      = r_data;
  assign o_index     = r_index;
  assign o_busy_mask = w_mask;

endmodule

// File: rtl/regwrite_arbiter.sv
// Purpose: shares the register bank's single write port between pipeline
//   writeback (priority, no backpressure) and a secondary long-latency result
//   source (valid/ready). Secondary results wait in a one-entry hold and drain
//   on writeback-idle cycles; a starvation counter stalls the pipeline to
//   force a bubble. A writeback to the held index discards the older result.
// Ports:
//   clk, rst                           : clock, synchronous active-high reset
//   wb_en, wb_data, wb_index           : writeback write request
//   sec_valid, sec_data, sec_index     : secondary result offer
//   sec_ready                          : secondary result accepted this cycle
//   stall                              : registered; pipeline must hold wb_en=0
//   waw_drop                           : a secondary result was discarded (WAW)
//   rf_write_en, rf_write, rf_write_index : register bank write port
//   busy_mask                          : one-hot of the held index, 0 when empty
module regwrite_arbiter
  import regwrite_arbiter_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned IDX_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wb_en,
  input  logic [DATA_W-1:0]   wb_data,
  input  logic [IDX_W-1:0]    wb_index,
  input  logic                sec_valid,
  input  logic [DATA_W-1:0]   sec_data,
  input  logic [IDX_W-1:0]    sec_index,
  output logic                sec_ready,
  output logic                stall,
  output logic                waw_drop,
  output logic                rf_write_en,
  output logic [DATA_W-1:0]   rf_write,
  output logic [IDX_W-1:0]    rf_write_index,
  output logic [2**IDX_W-1:0] busy_mask
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
  localparam int unsigned NREG  = 2 ** IDX_W;

  regwrite_state_t r_state;
  logic [CNT_W-1:0] r_wait_cnt;

  logic              w_hold_valid;
  logic [DATA_W-1:0] w_hold_data;
  logic [IDX_W-1:0]  w_hold_index;
  logic [NREG-1:0]   w_hold_mask;

  logic w_drain;
  logic w_sec_ready;
  logic w_accept;
  logic w_acc_waw;
  logic w_waw_clear;
  logic w_load;
  logic w_empty;

  // Handshake and WAW decisions for this cycle.
  assign w_drain     = !wb_en && w_hold_valid;
  assign w_sec_ready = !w_hold_valid || w_drain;
  assign w_accept    = sec_valid && w_sec_ready;
  // Accepted result already overwritten by a younger writeback: take it, drop it.
  assign w_acc_waw   = w_accept && wb_en && (sec_index == wb_index);
  assign w_waw_clear = wb_en && w_hold_valid && (wb_index == w_hold_index);
  assign w_load      = w_accept && !w_acc_waw;
  assign w_empty     = w_drain || w_waw_clear;

  regwrite_hold #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_hold (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_load),
    .i_clear     (w_empty),
    .i_data      (sec_data),
    .i_index     (sec_index),
    .o_valid     (w_hold_valid),
    .o_data      (w_hold_data),
    .o_index     (w_hold_index),
    .o_busy_mask (w_hold_mask)
  );

  // Starvation FSM: counts blocked cycles of the held entry, forces a stall
  // once MAX_WAIT of them have elapsed; any emptying restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_wait_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_load) begin
            r_state    <= PEND;
            r_wait_cnt <= '0;
          end
        end
        PEND, FORCE: begin
          if (w_empty) begin
            r_state    <= w_load ? PEND : IDLE;
            r_wait_cnt <= '0;
          end else begin
            // Not emptied while held means writeback took the port.
            if (r_wait_cnt != CNT_W'(MAX_WAIT)) begin
              r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            end
            if (r_state == PEND && r_wait_cnt == CNT_W'(MAX_WAIT - 1)) begin
              r_state <= FORCE;
            end
          end
        end
        default: begin
          r_state    <= IDLE;
          r_wait_cnt <= '0;
        end
      endcase
    end
  end

  // Write-port mux: writeback first, otherwise drain the hold.
  always_comb begin
    rf_write_en    = 1'b0;
    rf_write       = w_hold_data;
    rf_write_index = w_hold_index;
    if (!rst) begin
      rf_write_en = wb_en || w_hold_valid;
    end
    if (wb_en) begin
      rf_write       = wb_data;
      rf_write_index = wb_index;
    end
  end

  // All status outputs read as idle while reset is held.
  assign sec_ready = !rst && w_sec_ready;
  assign stall     = !rst && (r_state == FORCE);
  assign waw_drop  = !rst && (w_waw_clear || w_acc_waw);
  assign busy_mask = rst ? '0 : w_hold_mask;

endmodule

// File: tb/tb_regwrite_arbiter.sv
// Scoreboard bench for regwrite_arbiter: the stimulus process computes each
// cycle's expected outputs from a behavioural model and queues them; a monitor
// on the falling edge pops and compares against the DUT.
module tb_regwrite_arbiter;
  import regwrite_arbiter_pkg::*;

  localparam int unsigned MAX_WAIT = 4;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned IDX_W    = 4;

  logic              clk;
  logic              rst;
  logic              wb_en;
  logic [DATA_W-1:0] wb_data;
  logic [IDX_W-1:0]  wb_index;
  logic              sec_valid;
  logic [DATA_W-1:0] sec_data;
  logic [IDX_W-1:0]  sec_index;
  logic              sec_ready;
  logic              stall;
  logic              waw_drop;
  logic              rf_write_en;
  logic [DATA_W-1:0] rf_write;
  logic [IDX_W-1:0]  rf_write_index;
  logic [15:0]       busy_mask;

  regwrite_arbiter #(
    .MAX_WAIT (MAX_WAIT),
    .DATA_W   (DATA_W),
    .IDX_W    (IDX_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .wb_en          (wb_en),
    .wb_data        (wb_data),
    .wb_index       (wb_index),
    .sec_valid      (sec_valid),
    .sec_data       (sec_data),
    .sec_index      (sec_index),
    .sec_ready      (sec_ready),
    .stall          (stall),
    .waw_drop       (waw_drop),
    .rf_write_en    (rf_write_en),
    .rf_write       (rf_write),
    .rf_write_index (rf_write_index),
    .busy_mask      (busy_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    reg_write_t  wr;
    logic        ready;
    logic        stall;
    logic        waw;
    logic [15:0] mask;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Model state: at most one waiting secondary result and its blocked age.
  bit          m_held;
  logic [3:0]  m_idx;
  logic [31:0] m_data;
  int          m_blocked;
  bit          m_stall;
  bit          m_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  // Drive one cycle, queue its expected outputs, advance the model.
  task automatic step(input bit r, input bit we, input logic [3:0] wi, input logic [31:0] wd,
                      input bit sv, input logic [3:0] si, input logic [31:0] sd);
    exp_t e;
    bit drain, ready, wawc, acc, accw;
    rst = r; wb_en = we; wb_index = wi; wb_data = wd;
    sec_valid = sv; sec_index = si; sec_data = sd;
    e.wr = '0; e.ready = 1'b0; e.stall = 1'b0; e.waw = 1'b0; e.mask = '0;
    m_acc = 1'b0;
    if (r) begin
      m_held = 1'b0; m_blocked = 0; m_stall = 1'b0;
    end else begin
      drain = !we && m_held;
      ready = !m_held || drain;
      wawc  = we && m_held && (wi == m_idx);
      acc   = sv && ready;
      accw  = acc && we && (si == wi);
      if (we) begin
        e.wr.en = 1'b1; e.wr.index = wi; e.wr.data = wd;
      end else if (m_held) begin
        e.wr.en = 1'b1; e.wr.index = m_idx; e.wr.data = m_data;
      end
      e.ready = ready;
      e.stall = m_stall;
      e.waw   = wawc || accw;
      e.mask  = m_held ? (16'(1) << m_idx) : 16'(0);
      m_acc   = acc;
      if (acc && !accw) begin
        m_held = 1'b1; m_idx = si; m_data = sd; m_blocked = 0;
      end else if (drain || wawc) begin
        m_held = 1'b0; m_blocked = 0;
      end else if (m_held) begin
        m_blocked++;
      end
      m_stall = m_held && (m_blocked >= int'(MAX_WAIT));
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
  endtask

  // Monitor: compares one queued expectation per cycle, away from the edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("rf_write_en", 32'(rf_write_en), 32'(e.wr.en));
      if (e.wr.en) begin
        chk("rf_write_index", 32'(rf_write_index), 32'(e.wr.index));
        chk("rf_write", rf_write, e.wr.data);
      end
      chk("sec_ready", 32'(sec_ready), 32'(e.ready));
      chk("stall", 32'(stall), 32'(e.stall));
      chk("waw_drop", 32'(waw_drop), 32'(e.waw));
      chk("busy_mask", 32'(busy_mask), 32'(e.mask));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          pv;
    logic [3:0]  pi;
    logic [31:0] pd;
    bit          r, we;
    m_held = 1'b0; m_idx = '0; m_data = '0; m_blocked = 0; m_stall = 1'b0; m_acc = 1'b0;
    rst = 1'b1; wb_en = 1'b0; wb_data = '0; wb_index = '0;
    sec_valid = 1'b0; sec_data = '0; sec_index = '0;
    @(posedge clk);
    #1;

    // Reset state and reset mid-operation.
    step(1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    step(1'b0, 1'b1, 4'd1, 32'h1111_0000, 1'b1, 4'd5, 32'hDEAD_BEEF);
    step(1'b1, 1'b1, 4'd1, 32'h1111_0001, 1'b0, 4'd5, 32'hDEAD_BEEF);
    step(1'b0, 1'b1, 4'd1, 32'h1111_0002, 1'b0, 4'd0, 32'd0);
    idle(3);

    // Basic drain.
    step(1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd3, 32'h1234_5678);
    idle(2);

    // Writeback priority plus back-to-back secondary results.
    step(1'b0, 1'b1, 4'd7, 32'h7777_0001, 1'b1, 4'd1, 32'h0000_0A01);
    step(1'b0, 1'b1, 4'd7, 32'h7777_0002, 1'b1, 4'd2, 32'h0000_0A02);
    step(1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd2, 32'h0000_0A02);
    idle(2);

    // Starvation: stall after MAX_WAIT blocked cycles, release on a bubble.
    step(1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd10, 32'hCAFE_0010);
    for (int k = 0; k < 6; k++) step(1'b0, 1'b1, 4'd11, 32'(k), 1'b0, 4'd0, 32'd0);
    idle(3);

    // WAW: writeback hits the held index.
    step(1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd9, 32'h9999_9999);
    step(1'b0, 1'b1, 4'd9, 32'h0000_00AA, 1'b0, 4'd0, 32'd0);
    idle(3);
    // WAW: simultaneous accept and writeback to the same index.
    step(1'b0, 1'b1, 4'd12, 32'h0000_00BB, 1'b1, 4'd12, 32'h0000_00CC);
    idle(3);

    // Drain and accept in the same cycle.
    step(1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd4, 32'h4444_4444);
    step(1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd6, 32'h6666_6666);
    idle(2);

    // Randomized traffic honouring stall and sec_* stability.
    pv = 1'b0; pi = '0; pd = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!pv && $urandom_range(0, 2) != 0) begin
        pv = 1'b1;
        pi = 4'($urandom_range(0, 5));
        pd = $urandom;
      end
      we = m_stall ? 1'b0 : ($urandom_range(0, 99) < 60);
      r  = ($urandom_range(0, 199) == 0);
      step(r, we, 4'($urandom_range(0, 5)), $urandom, pv, pi, pd);
      if (m_acc) pv = 1'b0;
    end
    idle(2);

    @(negedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regwrite_arbiter.md
Name: regwrite_arbiter

Overview:
Shares the register bank's single write port between two sources: pipeline writeback, which has priority and no backpressure, and a secondary long-latency result source (load/multiply unit) using a valid/ready handshake.
- Secondary results wait in a one-entry hold register and drain on cycles when writeback is idle.
- A starvation counter raises a pipeline stall that forces a bubble for the drain.
- Sits between the writeback stage, the secondary unit and the register bank.

Parameters:
- MAX_WAIT, 4: blocked cycles tolerated before stall is asserted; must be >= 1.
- DATA_W, 32: register data width.
- IDX_W, 4: register index width (16 registers).

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  synchronous reset, active-high.
- wb_en  in  1  writeback write request (writeback stage write_en).
- wb_data  in  DATA_W  writeback data.
- wb_index  in  IDX_W  writeback destination register.
- sec_valid  in  1  secondary result valid.
- sec_data  in  DATA_W  secondary result data.
- sec_index  in  IDX_W  secondary destination register.
- sec_ready  out  1  arbiter accepts the secondary result this cycle.
- stall  out  1  registered; pipeline must deliver wb_en=0 while high.
- waw_drop  out  1  pulse: a secondary result was discarded due to WAW.
- rf_write_en  out  1  register bank write enable.
- rf_write  out  DATA_W  register bank write data.
- rf_write_index  out  IDX_W  register bank write index.
- busy_mask  out  2**IDX_W  one-hot index of the held entry; 0 when empty.

Behaviour:
- State: hold_valid/hold_data/hold_index, wait_cnt ($clog2(MAX_WAIT+1) bits, saturating), fsm in {IDLE, PEND, FORCE}.
- Reset (rst=1 at posedge): fsm=IDLE, hold_valid=0, wait_cnt=0. A held entry is lost; reset mid-operation behaves identically.
- Combinational outputs while rst=1: rf_write_en=0, sec_ready=0, stall=0, waw_drop=0, busy_mask=0.
- Port mux (combinational):
  - wb_en=1: rf_* = wb_*.
  - else hold_valid=1: rf_* = hold_*; this is a drain.
  - else rf_write_en=0.
  - rf_write/rf_write_index are don't-care when rf_write_en=0.
- Handshake:
  - sec_ready = !hold_valid || drain.
  - Accept = sec_valid && sec_ready; the accepted entry is loaded into hold at posedge.
  - A drain and an accept in the same cycle are allowed; the hold is refilled.
  - sec_data/sec_index must stay stable while sec_valid=1 && sec_ready=0.
- WAW rule: a writeback result is always program-order younger.
  - If wb_en=1 && hold_valid && wb_index==hold_index: the hold is cleared at posedge and waw_drop=1 that cycle.
  - If an accept occurs with sec_index==wb_index && wb_en=1: the entry is accepted but not stored, and waw_drop=1.
  - Both cases are counted as an emptying of the hold.
- FSM (all transitions at posedge):
  - IDLE: on accept -> PEND, wait_cnt=0.
  - PEND, drain or WAW clear:
    - -> IDLE, or stay PEND with wait_cnt=0 if a new entry was accepted.
  - PEND, blocked (wb_en=1, no WAW): wait_cnt++.
    - If wait_cnt==MAX_WAIT-1 before the increment -> FORCE.
  - FORCE: stall=1.
    - On drain or WAW clear -> IDLE/PEND as above, with wait_cnt=0.
    - While still blocked, remain in FORCE.
- Latency: accept at cycle N, earliest rf write at N+1.
- Minimum stall: stall rises at the start of the cycle after the MAX_WAIT-th blocked cycle.
- Throughput: one secondary result per cycle when writeback is idle.
- busy_mask: derived from registered hold_valid/hold_index only; no combinational dependence on inputs.
- Index 0 gets no special treatment; register-0 semantics belong to the register bank.

Decomposition:
- Shared types package:
  - regwrite_state_t enum {IDLE, PEND, FORCE};
  - REG_IDX_W=4, NUM_REGS=16;
  - packed struct reg_write_t {logic en; logic [3:0] index; logic [31:0] data} for the register-bank write bundle, reused by writeback.
- Natural sub-module: regwrite_hold, a one-entry hold register with load/clear/valid and busy_mask decode. The FSM and mux stay in regwrite_arbiter.

Test Plan:
- Reset mid-operation:
  - Accept idx=5 data=0xDEADBEEF, wb_en=1 every cycle, rst=1 on the 2nd cycle.
  - Next cycle hold empty, busy_mask=0, stall=0; no rf write of 0xDEADBEEF ever occurs.
- Basic drain:
  - wb_en=0; sec_valid=1 idx=3 data=0x12345678 at cycle 0.
  - Cycle 1: rf_write_en=1, index=3, data=0x12345678, busy_mask=0x0008.
  - Cycle 2: busy_mask=0.
- Priority plus back-to-back:
  - Two secondary results (idx 1, 2) while wb_en=1 idx=7 for 2 cycles.
  - rf writes in order: idx 7, 7, 1, 2.
  - sec_ready=0 while the hold is occupied and blocked.
- Starvation, MAX_WAIT=4:
  - Entry held from cycle 1, wb_en=1 continuously.
  - stall=1 from cycle 5 and stays high until the pipeline drops wb_en.
  - That cycle the hold drains; next cycle stall=0.
- WAW drop:
  - Hold idx=9, wb_en=1 idx=9 data=0xAA.
  - waw_drop=1 that cycle, rf writes 0xAA, and the hold never writes idx 9 afterwards.
  - Repeat with a simultaneous accept/wb to the same index.
- Drain+accept:
  - Hold idx=4; wb_en=0; sec_valid=1 idx=6 the same cycle.
  - rf writes idx 4 now and idx 6 next cycle; sec_ready stays 1 throughout.
